apb_config_master: RTL and testbench

APB initiator that drives config-space transfers into the APB-attached configuration memory. It accepts single read or write commands from a controller (boot loader or host bridge) over a valid/ready interface. Each command runs as one APB SETUP/ACCESS transaction, and the block returns a one-cycle response carrying read data and error status. A wait-state timeout protects against a hung or unresponsive slave.

---
 rtl/apb_config_master.sv | 101 ++++++++++
 tb/tb_apb_config_master.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_config_master.sv
// APB initiator: one SETUP/ACCESS transfer per accepted command, response 3+wait cycles after accept.
// Single outstanding command; cmd_ready only in IDLE, response is a one-cycle pulse with no backpressure.
module apb_config_master #(
  parameter int AW      = 16,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic          pclk,
  input  logic          prst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          rsp_timeout,
  output logic [15:0]   xfer_count,
  output logic          psel,
  output logic          penable,
  output logic          pwrite,
  output logic [AW-1:0] paddr,
  output logic [DW-1:0] pwdata,
  input  logic [DW-1:0] prdata,
  input  logic          pready,
  input  logic          pslverr
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  // Abort fires in the TIMEOUT-th ACCESS cycle; counter holds (ACCESS cycles - 1).
  localparam logic [TW-1:0] TLAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t        state;
  logic [TW-1:0] tcnt;

  assign cmd_ready = (state == IDLE) && !prst;

  always_ff @(posedge pclk) begin
    if (prst) begin
      state       <= IDLE;
      tcnt        <= '0;
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      xfer_count  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          // The APB address/data registers double as the command latch.
          if (cmd_valid) begin
            state   <= SETUP;
            tcnt    <= '0;
            psel    <= 1'b1;
            penable <= 1'b0;
            pwrite  <= cmd_write;
            paddr   <= cmd_addr;
            pwdata  <= cmd_write ? cmd_wdata : '0;
          end
        end
        SETUP: begin
          state   <= ACCESS;
          penable <= 1'b1;
        end
        ACCESS: begin
          if (pready) begin
            state       <= IDLE;
            psel        <= 1'b0;
            penable     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= pwrite ? '0 : prdata;
            rsp_err     <= pslverr;
            rsp_timeout <= 1'b0;
            xfer_count  <= xfer_count + 16'd1;
          end else if ((TIMEOUT != 0) && (tcnt == TLAST)) begin
            state       <= IDLE;
            psel        <= 1'b0;
            penable     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_config_master.sv
// Scoreboard bench for apb_config_master with a programmable wait-state / stuck slave model.
module tb_apb_config_master;

  logic        pclk = 1'b0;
  logic        prst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [15:0] xfer_count;
  logic        psel, penable, pwrite;
  logic [15:0] paddr;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr;

  int          n_vec = 0;
  int          n_bad = 0;
  int          exp_cnt = 0;

  int          wait_states = 0;
  bit          stuck = 1'b0;
  logic [31:0] slv_rdata = '0;
  logic        slv_err = 1'b0;
  int          acc_cnt = 0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
  } exp_t;

  exp_t sb[$];

  always #5 pclk = ~pclk;

  apb_config_master #(.AW(16), .DW(32), .TIMEOUT(8), .TW(8)) dut (
    .pclk(pclk), .prst(prst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout), .xfer_count(xfer_count),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  // Slave: pready rises after wait_states ACCESS cycles unless stuck.
  always @(posedge pclk) begin
    if (psel && penable) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end
  assign pready  = !stuck && (acc_cnt >= wait_states);
  assign prdata  = slv_rdata;
  assign pslverr = slv_err;

  task automatic drive_cmd(input logic w, input logic [15:0] a, input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
  endtask

  task automatic wait_rsp(input int budget, output bit got, output int cycles);
    got = 1'b0;
    cycles = 0;
    while (!got && cycles < budget) begin
      @(negedge pclk);
      cycles++;
      if (rsp_valid) got = 1'b1;
    end
  endtask

  // Issue one command, wait for acceptance and then for the response; cycles counts from the SETUP cycle.
  task automatic run_cmd(input logic w, input logic [15:0] a, input logic [31:0] d,
                         output bit got, output int cycles);
    bit acc = 1'b0;
    @(posedge pclk); #1;
    drive_cmd(w, a, d);
    for (int k = 0; k < 10 && !acc; k++) begin
      @(negedge pclk);
      if (cmd_ready) acc = 1'b1;
      else begin @(posedge pclk); #1; end
    end
    @(posedge pclk); #1;
    cmd_valid = 1'b0;
    got = 1'b0;
    cycles = 0;
    if (acc) wait_rsp(40, got, cycles);
  endtask

  task automatic test_reset();
    prst = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    n_vec++;
    if ({psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b want 000000", {psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout});
    end
    n_vec++;
    if ({paddr, pwdata, rsp_rdata, xfer_count} !== '0) begin
      n_bad++;
      $display("FAIL reset_data: got paddr=%h pwdata=%h rdata=%h cnt=%h want all 0", paddr, pwdata, rsp_rdata, xfer_count);
    end
    n_vec++;
    if (cmd_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ready: got %b want 0", cmd_ready);
    end
    @(posedge pclk); #1;
    prst = 1'b0;
    @(negedge pclk);
    n_vec++;
    if (cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL idle_ready: got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_write();
    exp_t e;
    sb.push_back(exp_t'{32'h0, 1'b0, 1'b0});
    exp_cnt++;
    @(posedge pclk); #1;
    drive_cmd(1'b1, 16'h0005, 32'hDEAD_BEEF);
    @(negedge pclk);
    n_vec++;
    if (cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL wr_accept: got ready=%b want 1", cmd_ready);
    end
    @(posedge pclk); #1;
    cmd_valid = 1'b0; cmd_wdata = '0;
    @(negedge pclk);
    n_vec++;
    if ({psel, penable, pwrite, paddr, pwdata} !== {1'b1, 1'b0, 1'b1, 16'h0005, 32'hDEAD_BEEF}) begin
      n_bad++;
      $display("FAIL wr_setup: got sel=%b en=%b wr=%b addr=%h wdata=%h want 1 0 1 0005 deadbeef",
               psel, penable, pwrite, paddr, pwdata);
    end
    @(negedge pclk);
    n_vec++;
    if ({psel, penable, pwrite, paddr, pwdata} !== {1'b1, 1'b1, 1'b1, 16'h0005, 32'hDEAD_BEEF}) begin
      n_bad++;
      $display("FAIL wr_access: got sel=%b en=%b wr=%b addr=%h wdata=%h want 1 1 1 0005 deadbeef",
               psel, penable, pwrite, paddr, pwdata);
    end
    @(negedge pclk);
    n_vec++;
    if ({rsp_valid, psel, penable} !== 3'b100) begin
      n_bad++;
      $display("FAIL wr_rsp_timing: got rsp_valid=%b sel=%b en=%b want 1 0 0", rsp_valid, psel, penable);
    end else begin
      e = sb.pop_front();
      n_vec++;
      if ({rsp_rdata, rsp_err, rsp_timeout} !== {e.rdata, e.err, e.tmo}) begin
        n_bad++;
        $display("FAIL wr_rsp: got rdata=%h err=%b tmo=%b want rdata=%h err=%b tmo=%b",
                 rsp_rdata, rsp_err, rsp_timeout, e.rdata, e.err, e.tmo);
      end
    end
    n_vec++;
    if (xfer_count !== 16'(exp_cnt)) begin
      n_bad++;
      $display("FAIL wr_count: got %0d want %0d", xfer_count, exp_cnt);
    end
  endtask

  task automatic test_read();
    exp_t e;
    bit   got;
    int   cyc;
    slv_rdata = 32'hDEAD_BEEF;
    sb.push_back(exp_t'{32'hDEAD_BEEF, 1'b0, 1'b0});
    exp_cnt++;
    run_cmd(1'b0, 16'h0005, 32'h1111_2222, got, cyc);
    n_vec++;
    if (!got || cyc != 3) begin
      n_bad++;
      $display("FAIL rd_latency: got seen=%b cycles=%0d want seen=1 cycles=3", got, cyc);
    end else begin
      e = sb.pop_front();
      n_vec++;
      if ({rsp_rdata, rsp_err, rsp_timeout} !== {e.rdata, e.err, e.tmo}) begin
        n_bad++;
        $display("FAIL rd_rsp: got rdata=%h err=%b tmo=%b want rdata=%h err=%b tmo=%b",
                 rsp_rdata, rsp_err, rsp_timeout, e.rdata, e.err, e.tmo);
      end
    end
    n_vec++;
    if ({pwrite, pwdata, xfer_count} !== {1'b0, 32'h0, 16'(exp_cnt)}) begin
      n_bad++;
      $display("FAIL rd_pwdata_count: got wr=%b wdata=%h cnt=%0d want 0 00000000 %0d", pwrite, pwdata, xfer_count, exp_cnt);
    end
  endtask

  task automatic test_wait_states();
    exp_t e;
    wait_states = 3;
    slv_rdata = 32'h1234_5678;
    sb.push_back(exp_t'{32'h1234_5678, 1'b0, 1'b0});
    exp_cnt++;
    @(posedge pclk); #1;
    drive_cmd(1'b0, 16'h0A0C, 32'hFFFF_FFFF);
    @(posedge pclk); #1;
    cmd_valid = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge pclk);
      if (i >= 2 && i <= 5) begin
        n_vec++;
        if ({psel, penable, pwrite, paddr, pwdata} !== {1'b1, 1'b1, 1'b0, 16'h0A0C, 32'h0}) begin
          n_bad++;
          $display("FAIL ws_access_c%0d: got sel=%b en=%b wr=%b addr=%h wdata=%h want 1 1 0 0a0c 00000000",
                   i, psel, penable, pwrite, paddr, pwdata);
        end
      end
      if (i < 6) begin
        n_vec++;
        if (rsp_valid !== 1'b0) begin
          n_bad++;
          $display("FAIL ws_early_rsp_c%0d: got rsp_valid=%b want 0", i, rsp_valid);
        end
      end
    end
    n_vec++;
    if (rsp_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL ws_rsp_timing: got rsp_valid=%b want 1 at N+6", rsp_valid);
    end else begin
      e = sb.pop_front();
      n_vec++;
      if ({rsp_rdata, rsp_err, rsp_timeout} !== {e.rdata, e.err, e.tmo}) begin
        n_bad++;
        $display("FAIL ws_rsp: got rdata=%h err=%b tmo=%b want rdata=%h err=%b tmo=%b",
                 rsp_rdata, rsp_err, rsp_timeout, e.rdata, e.err, e.tmo);
      end
    end
    wait_states = 0;
  endtask

  task automatic test_timeout();
    exp_t e;
    bit   got;
    int   cyc;
    stuck = 1'b1;
    slv_rdata = 32'hA5A5_A5A5;
    sb.push_back(exp_t'{32'h0, 1'b1, 1'b1});
    run_cmd(1'b0, 16'h0033, 32'h0, got, cyc);
    // SETUP + 8 ACCESS cycles, response in the 10th cycle after accept.
    n_vec++;
    if (!got || cyc != 10 || psel !== 1'b0 || penable !== 1'b0) begin
      n_bad++;
      $display("FAIL tmo_timing: got seen=%b cycles=%0d sel=%b en=%b want seen=1 cycles=10 sel=0 en=0",
               got, cyc, psel, penable);
    end
    if (got) begin
      e = sb.pop_front();
      n_vec++;
      if ({rsp_rdata, rsp_err, rsp_timeout} !== {e.rdata, e.err, e.tmo}) begin
        n_bad++;
        $display("FAIL tmo_rsp: got rdata=%h err=%b tmo=%b want rdata=%h err=%b tmo=%b",
                 rsp_rdata, rsp_err, rsp_timeout, e.rdata, e.err, e.tmo);
      end
    end
    n_vec++;
    if (xfer_count !== 16'(exp_cnt)) begin
      n_bad++;
      $display("FAIL tmo_count: got %0d want %0d", xfer_count, exp_cnt);
    end
    stuck = 1'b0;
    sb.push_back(exp_t'{32'h0, 1'b0, 1'b0});
    exp_cnt++;
    run_cmd(1'b1, 16'h0040, 32'h0000_00C3, got, cyc);
    n_vec++;
    if (!got || cyc != 3) begin
      n_bad++;
      $display("FAIL tmo_recover: got seen=%b cycles=%0d want seen=1 cycles=3", got, cyc);
    end else begin
      e = sb.pop_front();
      n_vec++;
      if ({rsp_rdata, rsp_err, rsp_timeout, xfer_count} !== {e.rdata, e.err, e.tmo, 16'(exp_cnt)}) begin
        n_bad++;
        $display("FAIL tmo_recover_rsp: got rdata=%h err=%b tmo=%b cnt=%0d want %h %b %b %0d",
                 rsp_rdata, rsp_err, rsp_timeout, xfer_count, e.rdata, e.err, e.tmo, exp_cnt);
      end
    end
  endtask

  task automatic test_slverr();
    exp_t e;
    bit   got;
    int   cyc;
    slv_err = 1'b1;
    slv_rdata = 32'hCAFE_F00D;
    for (int i = 0; i < 2; i++) begin
      logic w;
      w = (i == 0);
      sb.push_back(w ? exp_t'{32'h0, 1'b1, 1'b0} : exp_t'{32'hCAFE_F00D, 1'b1, 1'b0});
      exp_cnt++;
      run_cmd(w, 16'h0007 + 16'(i), 32'h0000_55AA, got, cyc);
      n_vec++;
      if (!got) begin
        n_bad++;
        $display("FAIL slverr_rsp_%0d: got no response want one", i);
      end else begin
        e = sb.pop_front();
        if ({rsp_rdata, rsp_err, rsp_timeout, xfer_count} !== {e.rdata, e.err, e.tmo, 16'(exp_cnt)}) begin
          n_bad++;
          $display("FAIL slverr_rsp_%0d: got rdata=%h err=%b tmo=%b cnt=%0d want %h %b %b %0d",
                   i, rsp_rdata, rsp_err, rsp_timeout, xfer_count, e.rdata, e.err, e.tmo, exp_cnt);
        end
      end
    end
    slv_err = 1'b0;
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    logic        w3 [3] = '{1'b1, 1'b0, 1'b1};
    logic [15:0] a3 [3] = '{16'h0100, 16'h0104, 16'h0108};
    logic [31:0] d3 [3] = '{32'h0000_0001, 32'h0000_0002, 32'h0000_0003};
    logic        hist [20];
    int          acc_c [3];
    int          k = 0;
    int          nrsp = 0;
    bit          acc;
    slv_rdata = 32'h0BAD_F00D;
    @(posedge pclk); #1;
    drive_cmd(w3[0], a3[0], d3[0]);
    for (int c = 0; c < 20; c++) begin
      @(negedge pclk);
      hist[c] = psel;
      if (rsp_valid) begin
        nrsp++;
        n_vec++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL b2b_extra_rsp: got unexpected response at c=%0d want none", c);
        end else begin
          e = sb.pop_front();
          if ({rsp_rdata, rsp_err, rsp_timeout} !== {e.rdata, e.err, e.tmo}) begin
            n_bad++;
            $display("FAIL b2b_rsp: got rdata=%h err=%b tmo=%b want rdata=%h err=%b tmo=%b",
                     rsp_rdata, rsp_err, rsp_timeout, e.rdata, e.err, e.tmo);
          end
        end
      end
      acc = cmd_valid && cmd_ready;
      if (acc) begin
        acc_c[k] = c;
        sb.push_back(w3[k] ? exp_t'{32'h0, 1'b0, 1'b0} : exp_t'{32'h0BAD_F00D, 1'b0, 1'b0});
        exp_cnt++;
        k++;
      end
      @(posedge pclk); #1;
      if (acc) begin
        if (k < 3) drive_cmd(w3[k], a3[k], d3[k]);
        else cmd_valid = 1'b0;
      end
    end
    n_vec++;
    if (k != 3 || nrsp != 3) begin
      n_bad++;
      $display("FAIL b2b_counts: got accepts=%0d rsps=%0d want 3 3", k, nrsp);
    end else begin
      n_vec++;
      if (acc_c[1] - acc_c[0] != 3 || acc_c[2] - acc_c[1] != 3) begin
        n_bad++;
        $display("FAIL b2b_cadence: got gaps %0d %0d want 3 3", acc_c[1] - acc_c[0], acc_c[2] - acc_c[1]);
      end
      n_vec++;
      if ({hist[acc_c[1]-1], hist[acc_c[1]], hist[acc_c[1]+1]} !== 3'b101) begin
        n_bad++;
        $display("FAIL b2b_psel_gap: got %b want 101", {hist[acc_c[1]-1], hist[acc_c[1]], hist[acc_c[1]+1]});
      end
    end
    n_vec++;
    if (xfer_count !== 16'(exp_cnt)) begin
      n_bad++;
      $display("FAIL b2b_count: got %0d want %0d", xfer_count, exp_cnt);
    end
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    stuck = 1'b1;
    @(posedge pclk); #1;
    drive_cmd(1'b0, 16'h0200, 32'h0);
    @(negedge pclk);
    n_vec++;
    if (cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_mid_accept: got ready=%b want 1", cmd_ready);
    end
    @(posedge pclk); #1;
    cmd_valid = 1'b0;
    @(posedge pclk); #1;
    prst = 1'b1;
    @(negedge pclk);
    n_vec++;
    if ({psel, penable} !== 2'b11) begin
      n_bad++;
      $display("FAIL rst_mid_access: got sel=%b en=%b want 1 1", psel, penable);
    end
    @(negedge pclk);
    n_vec++;
    if ({psel, penable, rsp_valid, xfer_count} !== {3'b000, 16'h0}) begin
      n_bad++;
      $display("FAIL rst_mid_clear: got sel=%b en=%b rsp=%b cnt=%0d want 0 0 0 0", psel, penable, rsp_valid, xfer_count);
    end
    @(posedge pclk); #1;
    prst = 1'b0;
    stuck = 1'b0;
    repeat (6) begin
      @(negedge pclk);
      if (rsp_valid) seen = 1'b1;
    end
    n_vec++;
    if (seen || cmd_ready !== 1'b1 || sb.size() != 0) begin
      n_bad++;
      $display("FAIL rst_mid_after: got rsp_seen=%b ready=%b pending=%0d want 0 1 0", seen, cmd_ready, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_wait_states();
    test_timeout();
    test_slverr();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000 want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
